// File: rtl/n64_pkg.sv
// n64_pkg: shared definitions for the N64 controller link.
//   - n64_state_e    : receiver FSM states
//   - N64_RESP_BITS  : bits in a controller status response
//   - N64_ZERO_MIN_US / N64_ZERO_MAX_US : bit-cell low-time thresholds in
//     microseconds (shared with the console-side transmitter)
package n64_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FALL,
        MEAS_LOW,
        WAIT_STOP
    } n64_state_e;

    localparam int N64_RESP_BITS   = 32;
    localparam int N64_ZERO_MIN_US = 2;   // low shorter than this -> logic 1
    localparam int N64_ZERO_MAX_US = 4;   // low longer than this  -> malformed

endpackage

// File: rtl/n64_edge_sync.sv
// n64_edge_sync: synchronizes the asynchronous controller line, optionally
// majority-filters it, and detects edges.
// Macro: N64_RX_GLITCH_FILTER_EN -- adds a 3-sample majority filter
//   (2 cycles extra latency, rejects 1-cycle pulses).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   data_in    : raw pad input, idle high
//   line       : cleaned line level
//   fall, rise : one-cycle edge strobes on line
module n64_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic line,
    output logic fall,
    output logic rise
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       maj;

    // Median of the current and two previous samples, then registered.
    assign maj = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            filt_q <= maj;
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b1;
        else        prev_q <= line;
    end

    assign fall = prev_q & ~line;
    assign rise = ~prev_q & line;

endmodule

// File: rtl/n64_rx.sv
// n64_rx: captures one 32-bit N64 controller response per arm pulse.
// Macro: N64_RX_GLITCH_FILTER_EN (see n64_edge_sync).
// Parameters: CLKS_PER_US (clk cycles per us), TIMEOUT_US (idle abort time).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   data_in    : controller data line, async, idle high
//   arm        : pulse to start a capture (ignored while busy)
//   buttons    : last good response, MSB = first bit received
//   valid      : one-cycle pulse when buttons updates
//   err        : one-cycle pulse on malformed bit or timeout
//   busy       : capture in progress
module n64_rx
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = 16,
    parameter int TIMEOUT_US  = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_in,
    input  logic                     arm,
    output logic [N64_RESP_BITS-1:0] buttons,
    output logic                     valid,
    output logic                     err,
    output logic                     busy
);

    localparam int          TIMEOUT_CYC = TIMEOUT_US * CLKS_PER_US;
    localparam int          IW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [9:0]  ONE_LIM     = 10'(N64_ZERO_MIN_US * CLKS_PER_US);
    localparam logic [9:0]  ZERO_LIM    = 10'(N64_ZERO_MAX_US * CLKS_PER_US);

    logic line, fall, rise;

    n64_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .line    (line),
        .fall    (fall),
        .rise    (rise)
    );

    n64_state_e               state_q, state_d;
    logic [9:0]               low_q, low_d;
    logic [5:0]               bits_q, bits_d;
    logic [N64_RESP_BITS-1:0] shift_q, shift_d;
    logic [N64_RESP_BITS-1:0] buttons_q, buttons_d;
    logic [IW-1:0]            idle_q, idle_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic                     timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            low_q     <= '0;
            bits_q    <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            idle_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            bits_q    <= bits_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            idle_q    <= idle_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // An edge always clears the idle counter, so a timeout can never
    // coincide with bit or stop classification.
    assign timeout = (state_q != IDLE) && !fall && !rise &&
                     (idle_q == IW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        bits_d    = bits_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (state_q == IDLE || fall || rise) idle_d = '0;
        else                                 idle_d = idle_q + IW'(1);

        // Low counter starts at 1 on the falling edge so that, at the rising
        // edge, it holds exactly the number of low cycles seen.
        if (state_q != IDLE && fall)
            low_d = 10'd1;
        else if ((state_q == MEAS_LOW || state_q == WAIT_STOP) && !line && low_q != '1)
            low_d = low_q + 10'd1;

        case (state_q)
            IDLE: begin
                // valid_q high marks the cycle just after a completion.
                if (arm && !valid_q) begin
                    state_d = WAIT_FALL;
                    bits_d  = '0;
                    low_d   = '0;
                end
            end
            WAIT_FALL: begin
                if (fall) state_d = MEAS_LOW;
            end
            MEAS_LOW: begin
                if (rise) begin
                    low_d = '0;
                    if (low_q > ZERO_LIM) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shift_d = {shift_q[N64_RESP_BITS-2:0], (low_q < ONE_LIM)};
                        bits_d  = bits_q + 6'd1;
                        state_d = (bits_q == 6'(N64_RESP_BITS - 1)) ? WAIT_STOP : WAIT_FALL;
                    end
                end
            end
            WAIT_STOP: begin
                if (rise) begin
                    low_d   = '0;
                    state_d = IDLE;
                    if (low_q <= ZERO_LIM) begin
                        buttons_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    assign buttons = buttons_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_n64_rx.sv
// Self-checking bench for n64_rx (CLKS_PER_US = 16).
module tb_n64_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_in = 1'b1;
    logic        arm = 1'b0;
    logic [31:0] buttons;
    logic        valid, err, busy;

    int checks = 0;
    int failures = 0;
    int valid_n = 0, err_n = 0, both_n = 0;

    int lows[$];
    int highs[$];
    int stop_low;
    logic [31:0] exp_buttons = '0;

    n64_rx #(.CLKS_PER_US(16), .TIMEOUT_US(200)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .arm     (arm),
        .buttons (buttons),
        .valid   (valid),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_n++;
        if (err) err_n++;
        if (valid && err) both_n++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        wait_cyc(1);
        arm = 1'b0;
    endtask

    // Reference decode from the bit-timing rules: L<32 -> 1, L<=64 -> 0,
    // longer -> malformed; stop pulse must be no longer than 64.
    task automatic model_decode(output bit ok, output logic [31:0] w);
        ok = 1'b1;
        w  = '0;
        for (int i = 0; i < 32; i++) begin
            if (lows[i] > 64) begin
                ok = 1'b0;
                return;
            end
            w = {w[30:0], (lows[i] < 32) ? 1'b1 : 1'b0};
        end
        if (stop_low > 64) ok = 1'b0;
    endtask

    task automatic build_frame(input logic [31:0] word, input int bad_bit);
        lows.delete();
        highs.delete();
        for (int i = 0; i < 32; i++) begin
            lows.push_back(word[31-i] ? int'($urandom_range(28, 4)) : int'($urandom_range(60, 36)));
            if (i == bad_bit) lows[i] = int'($urandom_range(100, 70));
            highs.push_back(int'($urandom_range(40, 8)));
        end
        stop_low = int'($urandom_range(60, 8));
    endtask

    task automatic drive_frame(input bit do_arm, input int mid_arm_bit,
                               input int glitch_bit, input bit send_stop);
        if (do_arm) begin
            pulse_arm();
            wait_cyc(5);
        end
        for (int i = 0; i < lows.size(); i++) begin
            data_in = 1'b0;
            wait_cyc(lows[i]);
            data_in = 1'b1;
            if (i == mid_arm_bit) begin
                wait_cyc(3);
                pulse_arm();
            end
            if (i == glitch_bit) begin
                wait_cyc(10);
                data_in = 1'b0;
                wait_cyc(1);
                data_in = 1'b1;
            end
            wait_cyc(highs[i]);
        end
        if (send_stop) begin
            data_in = 1'b0;
            wait_cyc(stop_low);
            data_in = 1'b1;
        end
        wait_cyc(10);
    endtask

    // Drives a prepared armed frame and checks it against the model.
    task automatic run_checked(input string tag, input int mid_arm_bit, input int glitch_bit);
        int  v0, e0;
        bit  ok;
        logic [31:0] w;
        v0 = valid_n;
        e0 = err_n;
        model_decode(ok, w);
        drive_frame(1'b1, mid_arm_bit, glitch_bit, 1'b1);
        if (ok) exp_buttons = w;
        check_eq({tag, "_valid"}, valid_n - v0, ok ? 1 : 0);
        check_eq({tag, "_err"}, err_n - e0, ok ? 0 : 1);
        check_eq({tag, "_buttons"}, buttons, exp_buttons);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int v0, e0, n;

        wait_cyc(3);
        check_eq("rst_buttons", buttons, 32'h0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Nominal 0x8000_00FF frame with exact 48/16 and 16/48 cells.
        lows.delete();
        highs.delete();
        begin
            logic [31:0] wd;
            wd = 32'h8000_00FF;
            for (int i = 0; i < 32; i++) begin
                lows.push_back(wd[31-i] ? 16 : 48);
                highs.push_back(wd[31-i] ? 48 : 16);
            end
        end
        stop_low = 32;
        v0 = valid_n;
        pulse_arm();
        wait_cyc(2);
        check_eq("arm_busy", busy, 1'b1);
        drive_frame(1'b0, -1, -1, 1'b1);
        check_eq("nom_valid", valid_n - v0, 1);
        check_eq("nom_buttons", buttons, 32'h8000_00FF);
        check_eq("nom_busy", busy, 1'b0);
        exp_buttons = 32'h8000_00FF;

        // Threshold boundaries: 31 -> 1, 32 -> 0, 64 -> 0, stop of 64 accepted.
        build_frame(32'h5A5A_C3C3, -1);
        lows[0] = 31; lows[1] = 32; lows[2] = 64; lows[3] = 64;
`ifdef N64_RX_GLITCH_FILTER_EN
        lows[4] = 2;
`else
        lows[4] = 1;
`endif
        stop_low = 64;
        run_checked("bound", -1, -1);

        // Malformed bit: 5 bits then a 70-cycle low.
        build_frame(32'hFFFF_FFFF, 5);
        lows[5] = 70;
        run_checked("long_low", -1, -1);

        // Stop pulse too long is rejected.
        build_frame(32'h0F0F_0F0F, -1);
        stop_low = 65;
        run_checked("long_stop", -1, -1);

        // Timeout with line held high after arm.
        e0 = err_n;
        pulse_arm();
        n = 0;
        while (err_n == e0 && n < 3400) begin
            wait_cyc(1);
            n++;
        end
        check_eq("to_err", err_n - e0, 1);
        check_eq("to_window", (n >= 3190 && n <= 3210) ? 1 : 0, 1);
        check_eq("to_busy", busy, 1'b0);
        check_eq("to_buttons", buttons, exp_buttons);

        // Randomized frames, some with a malformed bit.
        for (int k = 0; k < 6; k++) begin
            build_frame($urandom, ($urandom_range(2, 0) == 0) ? int'($urandom_range(31, 0)) : -1);
            run_checked("rand", -1, -1);
        end

        // Second arm while busy is ignored.
        build_frame(32'hFFFF_FFFF, -1);
        run_checked("rearm", 10, -1);

        // Frame without arm produces nothing.
        build_frame(32'hA5A5_0001, -1);
        v0 = valid_n;
        e0 = err_n;
        drive_frame(1'b0, -1, -1, 1'b1);
        check_eq("noarm_valid", valid_n - v0, 0);
        check_eq("noarm_err", err_n - e0, 0);
        check_eq("noarm_buttons", buttons, exp_buttons);

        // Reset after 20 bits, then an unarmed 0x1234_5678 frame.
        build_frame(32'hCAFE_F00D, -1);
        lows = lows[0:19];
        highs = highs[0:19];
        v0 = valid_n;
        e0 = err_n;
        drive_frame(1'b1, -1, -1, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        check_eq("mid_rst_busy", busy, 1'b0);
        build_frame(32'h1234_5678, -1);
        drive_frame(1'b0, -1, -1, 1'b1);
        check_eq("mid_rst_valid", valid_n - v0, 0);
        check_eq("mid_rst_err", err_n - e0, 0);
        check_eq("mid_rst_buttons", buttons, 32'h0);
        exp_buttons = '0;

`ifdef N64_RX_GLITCH_FILTER_EN
        // 1-cycle low glitch inside a high phase must be rejected.
        build_frame(32'h0000_0001, -1);
        run_checked("glitch", -1, 7);
        check_eq("glitch_word", buttons, 32'h0000_0001);
`endif

        check_eq("valid_err_overlap", both_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n64_rx.md
N64_RX -- requirements
Module: n64_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 16, meaning clk cycles per microsecond.
REQ-002 SHALL have parameter TIMEOUT_US, default 200, meaning the maximum idle time while busy before aborting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 1 bit: controller data line from the pad, asynchronous to clk, idle high.
REQ-006 SHALL have port arm, input, 1 bit: single-cycle pulse that starts one 32-bit response capture.
REQ-007 SHALL have port buttons, output, 32 bits: last good response, MSB = first bit received.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when buttons is updated.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse on a malformed bit or a timeout.
REQ-010 SHALL have port busy, output, 1 bit: high from the arm acceptance cycle until completion or abort.

Function
REQ-011 data_in SHALL pass through a 2-flop synchronizer; falling and rising edges are detected on the synchronized signal.
REQ-012 States SHALL be IDLE, WAIT_FALL, MEAS_LOW, WAIT_STOP.
- IDLE -> WAIT_FALL on arm.
- WAIT_FALL -> MEAS_LOW on a falling edge.
- MEAS_LOW -> WAIT_FALL on a rising edge while bits < 32.
- MEAS_LOW -> WAIT_STOP on the rising edge of bit 32.
- WAIT_STOP -> IDLE on the stop pulse's rising edge.
REQ-013 In MEAS_LOW a low counter SHALL increment every cycle (saturating, 10 bits).
REQ-014 On the rising edge, the bit SHALL be classified by low-cycle count L:
- L < 2*CLKS_PER_US: logic 1.
- 2*CLKS_PER_US <= L <= 4*CLKS_PER_US: logic 0.
- L > 4*CLKS_PER_US: err, go to IDLE, buttons unchanged.
REQ-015 Bits SHALL shift into a 32-bit shift register MSB-first; a 6-bit bit counter counts 0..32.
REQ-016 The stop pulse SHALL be any low pulse not longer than 4*CLKS_PER_US; on its rising edge buttons <= shift register and valid pulses, in the cycle after the edge is detected.
REQ-017 An idle counter SHALL reset on every edge; if it reaches TIMEOUT_US*CLKS_PER_US while in a non-IDLE state, err pulses and the FSM goes to IDLE.
REQ-018 arm SHALL be ignored while busy; arm coincident with a completion SHALL also be ignored.
REQ-019 valid and err SHALL never be asserted in the same cycle.
REQ-020 A falling edge seen in IDLE SHALL be ignored (no capture without arm).

Reset
REQ-021 While rst_n is low:
- buttons = 0, valid = 0, err = 0, busy = 0;
- state IDLE, all counters 0;
- synchronizer flops = 1.
REQ-022 Reset asserted mid-capture SHALL discard the partial word without any valid or err pulse; after release the block waits in IDLE for arm.

Configuration
REQ-023 With N64_RX_GLITCH_FILTER_EN defined, the synchronized line SHALL pass through a 3-sample majority filter before edge detection. This adds 2 cycles of latency and rejects pulses of 1 cycle.
REQ-024 Without N64_RX_GLITCH_FILTER_EN, edges SHALL be taken directly from the synchronizer output, and 1-cycle pulses are decoded as logic 1.

Structure
REQ-025 Package n64_pkg SHALL hold:
- the state enum;
- N64_RESP_BITS = 32;
- the bit-threshold multipliers (2 us and 4 us), shared with the console-side transmitter.
REQ-026 Sub-module n64_edge_sync SHALL contain the synchronizer, the optional filter and the edge detector, with outputs line, fall and rise.

Verification (CLKS_PER_US = 16)
REQ-027 Scenario: arm, then 32 bits encoding 0x8000_00FF (bit 0 = 48 low/16 high, bit 1 = 16 low/48 high), then a stop pulse of 32 low -> required response: valid for exactly 1 cycle, buttons = 0x8000_00FF, busy low afterward.
REQ-028 Scenario: arm, 5 bits, then a 70-cycle low pulse -> required response: err for 1 cycle at its rising edge, buttons keeps its prior value.
REQ-029 Scenario: arm, then data_in held high for 3200 cycles -> required response: err at the timeout, state IDLE, busy = 0.
REQ-030 Scenario: rst_n pulled low after 20 bits, then released, then a full 0x1234_5678 frame without arm -> required response: no valid; buttons = 0.
REQ-031 Scenario: second arm while busy during a 0xFFFF_FFFF frame -> required response: exactly one valid, buttons = 0xFFFF_FFFF.
REQ-032 Scenario: with N64_RX_GLITCH_FILTER_EN, a 1-cycle low glitch inside a high phase of a 0x0000_0001 frame -> required response: buttons = 0x0000_0001, no err.
